// File: rtl/frv_dmem_arbiter_pkg.sv
// frv_dmem_arbiter_pkg: owner ids and FSM state encodings for the data-memory arbiter
package frv_dmem_arbiter_pkg;
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;
endpackage

// File: rtl/frv_arb_owner_fifo.sv
// frv_arb_owner_fifo: 1-bit synchronous FIFO recording which requester owns each outstanding transaction
module frv_arb_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic g_clk,
  input  logic g_resetn,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o  = mem_q[rd_q];
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1);
      end
      if (pop_i)
        rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/frv_dmem_arbiter.sv
// frv_dmem_arbiter: shares the data-memory port between LSU (m0) and aux master (m1), routing responses by owner.
// Define FRV_DMEM_ARB_STARVE_EN to promote m1 after STARVE_LIMIT consecutive losses.
module frv_dmem_arbiter
  import frv_dmem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        m0_req,
  input  logic        m0_wen,
  input  logic [3:0]  m0_strb,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_recv,
  input  logic        m0_ack,
  output logic        m0_error,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wen,
  input  logic [3:0]  m1_strb,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_recv,
  input  logic        m1_ack,
  output logic        m1_error,
  output logic [31:0] m1_rdata,
  output logic        dmem_req,
  output logic        dmem_wen,
  output logic [3:0]  dmem_strb,
  output logic [31:0] dmem_wdata,
  output logic [31:0] dmem_addr,
  input  logic        dmem_gnt,
  input  logic        dmem_recv,
  output logic        dmem_ack,
  input  logic        dmem_error,
  input  logic [31:0] dmem_rdata
);
  if (OUTSTANDING < 1 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("frv_dmem_arbiter: OUTSTANDING and STARVE_LIMIT must be >= 1");
  end
  arb_state_e state_q, state_d;
  logic sel, sel_req, prefer_m1, hs, full, empty, owner, live;
  always_comb begin
    live       = dmem_recv && !empty;
    sel        = state_q == ST_LOCK1 || (state_q == ST_IDLE && (prefer_m1 ? m1_req : !m0_req));
    sel_req    = sel ? m1_req : m0_req;
    dmem_req   = g_resetn && sel_req && !full;
    dmem_wen   = sel ? m1_wen   : m0_wen;
    dmem_strb  = sel ? m1_strb  : m0_strb;
    dmem_wdata = sel ? m1_wdata : m0_wdata;
    dmem_addr  = sel ? m1_addr  : m0_addr;
    hs         = dmem_req && dmem_gnt;
    m0_gnt     = hs && sel == ARB_M0;
    m1_gnt     = hs && sel == ARB_M1;
    m0_recv    = g_resetn && live && owner == ARB_M0;
    m1_recv    = g_resetn && live && owner == ARB_M1;
    dmem_ack   = g_resetn && live && (owner == ARB_M1 ? m1_ack : m0_ack);
    m0_rdata   = dmem_rdata;
    m1_rdata   = dmem_rdata;
    m0_error   = dmem_error;
    m1_error   = dmem_error;
    state_d    = state_q == ST_IDLE ? (dmem_req && !dmem_gnt ? (sel ? ST_LOCK1 : ST_LOCK0) : ST_IDLE)
                                    : (hs ? ST_IDLE : state_q);
  end
  always_ff @(posedge g_clk) begin
    if (!g_resetn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end
`ifdef FRV_DMEM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;
  always_comb begin
    prefer_m1 = starve_q == SW'(STARVE_LIMIT);
    starve_d  = m1_gnt ? '0
              : (state_q == ST_IDLE && m1_req && sel == ARB_M0 && !prefer_m1) ? starve_q + SW'(1)
              : starve_q;
  end
  always_ff @(posedge g_clk) begin
    if (!g_resetn) starve_q <= '0;
    else           starve_q <= starve_d;
  end
`else
  assign prefer_m1 = 1'b0;
`endif
  frv_arb_owner_fifo #(.DEPTH(OUTSTANDING)) u_owner_fifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .push_i   (hs),
    .din_i    (sel),
    .pop_i    (dmem_ack),
    .full_o   (full),
    .empty_o  (empty),
    .head_o   (owner)
  );
  // A response with no outstanding owner is a bus protocol violation; it is dropped unacknowledged.
  always_ff @(posedge g_clk) begin
    if (g_resetn) assert (!(dmem_recv && empty));
  end
endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// tb_frv_dmem_arbiter: directed checks of arbitration, locking, owner routing, FIFO-full stall and reset.
module tb_frv_dmem_arbiter;
  logic        clk = 1'b0;
  logic        g_resetn;
  logic        m0_req, m0_wen, m0_ack, m1_req, m1_wen, m1_ack;
  logic [3:0]  m0_strb, m1_strb;
  logic [31:0] m0_wdata, m0_addr, m1_wdata, m1_addr;
  logic        m0_gnt, m0_recv, m0_error, m1_gnt, m1_recv, m1_error;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_ack, dmem_error;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_wdata, dmem_addr, dmem_rdata;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  frv_dmem_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(8)) dut (
    .g_clk(clk), .g_resetn(g_resetn),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_strb(m0_strb), .m0_wdata(m0_wdata), .m0_addr(m0_addr),
    .m0_gnt(m0_gnt), .m0_recv(m0_recv), .m0_ack(m0_ack), .m0_error(m0_error), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_strb(m1_strb), .m1_wdata(m1_wdata), .m1_addr(m1_addr),
    .m1_gnt(m1_gnt), .m1_recv(m1_recv), .m1_ack(m1_ack), .m1_error(m1_error), .m1_rdata(m1_rdata),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
    .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt), .dmem_recv(dmem_recv), .dmem_ack(dmem_ack),
    .dmem_error(dmem_error), .dmem_rdata(dmem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  int g0, g1, first1;
  initial begin
    g_resetn = 0;
    {m0_req, m0_wen, m0_ack, m1_req, m1_wen, m1_ack} = '0;
    {m0_strb, m1_strb} = '0;
    {m0_wdata, m0_addr, m1_wdata, m1_addr} = '0;
    {dmem_gnt, dmem_recv, dmem_error} = '0;
    dmem_rdata = '0;
    tick; tick; #1;
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_recv", m1_recv, 0);
    chk("rst_dmem_ack", dmem_ack, 0);
    // single m0 store, granted the same cycle
    tick; g_resetn = 1;
    tick; m0_req = 1; m0_wen = 1; m0_strb = 4'hF; m0_addr = 32'h100; m0_wdata = 32'hDEADBEEF; dmem_gnt = 1; #1;
    chk("st_dmem_req", dmem_req, 1);
    chk("st_addr", dmem_addr, 32'h100);
    chk("st_strb", dmem_strb, 4'hF);
    chk("st_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("st_m0_gnt", m0_gnt, 1);
    chk("st_m1_gnt", m1_gnt, 0);
    tick; m0_req = 0; m0_wen = 0; dmem_gnt = 0; dmem_recv = 1; dmem_rdata = 32'h1234; dmem_error = 1; m0_ack = 1; #1;
    chk("st_m0_recv", m0_recv, 1);
    chk("st_m1_recv", m1_recv, 0);
    chk("st_rdata", m0_rdata, 32'h1234);
    chk("st_error", m0_error, 1);
    chk("st_ack", dmem_ack, 1);
    tick; dmem_recv = 0; dmem_error = 0; #1;
    chk("st_idle_req", dmem_req, 0);
    // simultaneous requests: m0 first, then m1; responses in order
    tick; m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20; dmem_gnt = 1; #1;
    chk("both_m0_gnt", m0_gnt, 1);
    chk("both_m1_gnt0", m1_gnt, 0);
    chk("both_addr0", dmem_addr, 32'h10);
    tick; m0_req = 0; dmem_recv = 1; m0_ack = 1; m1_ack = 1; #1;
    chk("both_m1_gnt", m1_gnt, 1);
    chk("both_addr1", dmem_addr, 32'h20);
    chk("both_recv0", m0_recv, 1);
    tick; m1_req = 0; dmem_gnt = 0; #1;
    chk("both_recv1", m1_recv, 1);
    chk("both_recv1_m0", m0_recv, 0);
    tick; dmem_recv = 0;
    // m1 locked while the bus withholds grant, m0 arriving later must wait
    tick; m1_req = 1; m1_addr = 32'h300; m0_addr = 32'h400; #1;
    chk("lk_addr_c0", dmem_addr, 32'h300);
    chk("lk_m1_gnt_c0", m1_gnt, 0);
    tick; m0_req = 1; #1;
    chk("lk_addr_c1", dmem_addr, 32'h300);
    tick; #1;
    chk("lk_addr_c2", dmem_addr, 32'h300);
    chk("lk_m0_gnt_c2", m0_gnt, 0);
    tick; dmem_gnt = 1; #1;
    chk("lk_m1_gnt", m1_gnt, 1);
    chk("lk_m0_gnt", m0_gnt, 0);
    tick; m1_req = 0; #1;
    chk("lk_then_m0", m0_gnt, 1);
    tick; m0_req = 0; dmem_gnt = 0; dmem_recv = 1; #1;
    chk("lk_resp_m1", m1_recv, 1);
    tick; #1;
    chk("lk_resp_m0", m0_recv, 1);
    tick; dmem_recv = 0;
    // owner FIFO full: third request stalls until a slot is freed
    tick; m0_req = 1; m0_addr = 32'h200; dmem_gnt = 1; #1;
    chk("ff_g1", m0_gnt, 1);
    tick; #1;
    chk("ff_g2", m0_gnt, 1);
    tick; #1;
    chk("ff_full_req", dmem_req, 0);
    chk("ff_full_gnt", m0_gnt, 0);
    tick; dmem_recv = 1; #1;
    chk("ff_pop_ack", dmem_ack, 1);
    chk("ff_pop_gnt", m0_gnt, 0);
    tick; dmem_recv = 0; #1;
    chk("ff_g3", m0_gnt, 1);
    tick; m0_req = 0; dmem_gnt = 0; dmem_recv = 1; #1;
    chk("ff_drain1", m0_recv, 1);
    tick; #1;
    chk("ff_drain2", m0_recv, 1);
    tick; dmem_recv = 0;
    // continuous contention: starvation promotion only when enabled
    g0 = 0; g1 = 0; first1 = -1;
    for (int k = 0; k < 12; k++) begin
      tick; m0_req = 1; m1_req = 1; dmem_gnt = 1; dmem_recv = (k > 0); #1;
      if (m1_gnt && first1 < 0) first1 = g0;
      g0 += int'(m0_gnt);
      g1 += int'(m1_gnt);
    end
`ifdef FRV_DMEM_ARB_STARVE_EN
    chk("sv_first_m1_after", first1, 8);
    chk("sv_m1_grants", g1, 1);
`else
    chk("sv_m1_grants", g1, 0);
    chk("sv_m0_grants", g0, 12);
`endif
    tick; m0_req = 0; m1_req = 0; dmem_gnt = 0; dmem_recv = 1; #1;
    chk("sv_drain", dmem_ack, 1);
    tick; dmem_recv = 0;
    // reset with two outstanding transactions
    tick; m0_req = 1; m0_addr = 32'h500; dmem_gnt = 1; #1;
    chk("rr_g1", m0_gnt, 1);
    tick; #1;
    chk("rr_g2", m0_gnt, 1);
    tick; g_resetn = 0; dmem_recv = 1; #1;
    tick; #1;
    chk("rr_req", dmem_req, 0);
    chk("rr_gnt", m0_gnt, 0);
    chk("rr_recv", m0_recv, 0);
    chk("rr_ack", dmem_ack, 0);
    m0_req = 0; dmem_recv = 0; dmem_gnt = 0;
    tick; g_resetn = 1;
    tick; m1_req = 1; m1_addr = 32'h600; #1;
    chk("rr_post_req", dmem_req, 1);
    chk("rr_post_addr", dmem_addr, 32'h600);
    tick; dmem_gnt = 1; #1;
    chk("rr_post_gnt", m1_gnt, 1);
    tick; m1_req = 0; dmem_gnt = 0; dmem_recv = 1; #1;
    chk("rr_post_recv", m1_recv, 1);
    tick; dmem_recv = 0;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
